// File: rtl/spu_pkg.sv
// spu_pkg: shared SPU register-file sizes, execution-unit codes and forwarding-chain types.
package spu_pkg;
  localparam int W = 128;
  localparam int NREG = 128;
  localparam int FWD = 7;
  localparam logic [1:0] UNIT_FP = 2'd0;
  localparam logic [1:0] UNIT_FX2 = 2'd1;
  localparam logic [1:0] UNIT_BYTE = 2'd2;
  localparam logic [1:0] UNIT_FX1 = 2'd3;
  typedef logic [FWD-1:0][W-1:0] fw_data_t;
  typedef logic [FWD-1:0][6:0] fw_addr_t;
endpackage

// File: rtl/even_rf_fwd_if.sv
// even_rf_fwd_if: decode, writeback, forwarding and result bundle of the even-pipe RF/FWD stage.
interface even_rf_fwd_if;
  import spu_pkg::*;
  logic [0:10] op_in;
  logic [2:0] format_in;
  logic [1:0] unit_in;
  logic [6:0] rt_addr_in;
  logic [6:0] ra_addr;
  logic [6:0] rb_addr;
  logic [6:0] rc_addr;
  logic [17:0] imm_in;
  logic reg_write_in;
  logic [W-1:0] rt_wb_e;
  logic [6:0] rt_addr_wb_e;
  logic reg_write_wb_e;
  logic [W-1:0] rt_wb_o;
  logic [6:0] rt_addr_wb_o;
  logic reg_write_wb_o;
  fw_data_t fw_e;
  fw_addr_t fw_addr_e;
  logic [FWD-1:0] fw_write_e;
  fw_data_t fw_o;
  fw_addr_t fw_addr_o;
  logic [FWD-1:0] fw_write_o;
  logic [0:10] op;
  logic [2:0] format;
  logic [1:0] unit;
  logic [6:0] rt_addr;
  logic [17:0] imm;
  logic reg_write;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] rc;
  modport master (
    output op_in, format_in, unit_in, rt_addr_in, ra_addr, rb_addr, rc_addr, imm_in, reg_write_in,
    output rt_wb_e, rt_addr_wb_e, reg_write_wb_e, rt_wb_o, rt_addr_wb_o, reg_write_wb_o,
    output fw_e, fw_addr_e, fw_write_e, fw_o, fw_addr_o, fw_write_o,
    input op, format, unit, rt_addr, imm, reg_write, ra, rb, rc
  );
  modport slave (
    input op_in, format_in, unit_in, rt_addr_in, ra_addr, rb_addr, rc_addr, imm_in, reg_write_in,
    input rt_wb_e, rt_addr_wb_e, reg_write_wb_e, rt_wb_o, rt_addr_wb_o, reg_write_wb_o,
    input fw_e, fw_addr_e, fw_write_e, fw_o, fw_addr_o, fw_write_o,
    output op, format, unit, rt_addr, imm, reg_write, ra, rb, rc
  );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: priority operand mux; youngest chain entry first (even before odd), then writeback even/odd, then array.
module fwd_select #(
  parameter int W = 128,
  parameter int FWD = 7
) (
  input  logic [6:0] addr,
  input  logic [W-1:0] rd,
  input  logic [FWD-1:0][W-1:0] fw_e,
  input  logic [FWD-1:0][6:0] fw_addr_e,
  input  logic [FWD-1:0] fw_write_e,
  input  logic [FWD-1:0][W-1:0] fw_o,
  input  logic [FWD-1:0][6:0] fw_addr_o,
  input  logic [FWD-1:0] fw_write_o,
  input  logic [W-1:0] wb_e,
  input  logic [6:0] wb_addr_e,
  input  logic wb_write_e,
  input  logic [W-1:0] wb_o,
  input  logic [6:0] wb_addr_o,
  input  logic wb_write_o,
  output logic [W-1:0] q
);
  // Lowest priority is assigned first so each later hit overrides it.
  always_comb begin
    q = rd;
    if (wb_write_o && wb_addr_o == addr) q = wb_o;
    if (wb_write_e && wb_addr_e == addr) q = wb_e;
    for (int i = FWD - 1; i >= 0; i--) begin
      if (fw_write_o[i] && fw_addr_o[i] == addr) q = fw_o[i];
      if (fw_write_e[i] && fw_addr_e[i] == addr) q = fw_e[i];
    end
  end
endmodule

// File: rtl/even_rf_fwd.sv
// even_rf_fwd: SPU register file with forwarding-resolved operand fetch, registered toward the even pipe.
module even_rf_fwd #(
  parameter int NREG = spu_pkg::NREG,
  parameter int W = spu_pkg::W,
  parameter int FWD = spu_pkg::FWD
) (
  input logic clk,
  input logic reset,
  even_rf_fwd_if.slave bus
);
  logic [W-1:0] regs [NREG];
  logic [2:0][6:0] src;
  logic [2:0][W-1:0] res;
  assign src = {bus.rc_addr, bus.rb_addr, bus.ra_addr};
  // Even write is issued last so it wins when both ports hit one register.
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else begin
      if (bus.reg_write_wb_o) regs[bus.rt_addr_wb_o] <= bus.rt_wb_o;
      if (bus.reg_write_wb_e) regs[bus.rt_addr_wb_e] <= bus.rt_wb_e;
    end
  for (genvar j = 0; j < 3; j++) begin : g_sel
    fwd_select #(.W(W), .FWD(FWD)) u_sel (
      .addr(src[j]),
      .rd(regs[src[j]]),
      .fw_e(bus.fw_e),
      .fw_addr_e(bus.fw_addr_e),
      .fw_write_e(bus.fw_write_e),
      .fw_o(bus.fw_o),
      .fw_addr_o(bus.fw_addr_o),
      .fw_write_o(bus.fw_write_o),
      .wb_e(bus.rt_wb_e),
      .wb_addr_e(bus.rt_addr_wb_e),
      .wb_write_e(bus.reg_write_wb_e),
      .wb_o(bus.rt_wb_o),
      .wb_addr_o(bus.rt_addr_wb_o),
      .wb_write_o(bus.reg_write_wb_o),
      .q(res[j])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.op <= '0;
      bus.format <= '0;
      bus.unit <= '0;
      bus.rt_addr <= '0;
      bus.imm <= '0;
      bus.reg_write <= 1'b0;
      bus.ra <= '0;
      bus.rb <= '0;
      bus.rc <= '0;
    end else begin
      bus.op <= bus.op_in;
      bus.format <= bus.format_in;
      bus.unit <= bus.unit_in;
      bus.rt_addr <= bus.rt_addr_in;
      bus.imm <= bus.imm_in;
      bus.reg_write <= bus.reg_write_in;
      bus.ra <= res[0];
      bus.rb <= res[1];
      bus.rc <= res[2];
    end
endmodule

// File: tb/tb_even_rf_fwd.sv
// tb_even_rf_fwd: scoreboard bench for even_rf_fwd with directed cases and randomized traffic.
module tb_even_rf_fwd;
  import spu_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  even_rf_fwd_if bus();
  even_rf_fwd dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [41:0] ctl;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rc;
  } exp_t;
  exp_t q[$];
  logic [W-1:0] mem [NREG];
  int checks = 0;
  int fails = 0;
  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic logic [W-1:0] resolve(input logic [6:0] a);
    for (int i = 0; i < FWD; i++) begin
      if (bus.fw_write_e[i] && bus.fw_addr_e[i] == a) return bus.fw_e[i];
      if (bus.fw_write_o[i] && bus.fw_addr_o[i] == a) return bus.fw_o[i];
    end
    if (bus.reg_write_wb_e && bus.rt_addr_wb_e == a) return bus.rt_wb_e;
    if (bus.reg_write_wb_o && bus.rt_addr_wb_o == a) return bus.rt_wb_o;
    return mem[a];
  endfunction
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic clr();
    {bus.op_in, bus.format_in, bus.unit_in, bus.rt_addr_in, bus.imm_in, bus.reg_write_in} = '0;
    {bus.ra_addr, bus.rb_addr, bus.rc_addr} = '0;
    {bus.rt_wb_e, bus.rt_addr_wb_e, bus.reg_write_wb_e} = '0;
    {bus.rt_wb_o, bus.rt_addr_wb_o, bus.reg_write_wb_o} = '0;
    bus.fw_e = '0;
    bus.fw_addr_e = '0;
    bus.fw_write_e = '0;
    bus.fw_o = '0;
    bus.fw_addr_o = '0;
    bus.fw_write_o = '0;
  endtask
  // Predict the response to the current inputs, then advance the architectural register model.
  task automatic cyc();
    exp_t e;
    if (reset) begin
      e.ctl = '0;
      e.ra = '0;
      e.rb = '0;
      e.rc = '0;
      for (int i = 0; i < NREG; i++) mem[i] = '0;
    end else begin
      e.ctl = {bus.op_in, bus.format_in, bus.unit_in, bus.rt_addr_in, bus.imm_in, bus.reg_write_in};
      e.ra = resolve(bus.ra_addr);
      e.rb = resolve(bus.rb_addr);
      e.rc = resolve(bus.rc_addr);
      if (bus.reg_write_wb_o) mem[bus.rt_addr_wb_o] = bus.rt_wb_o;
      if (bus.reg_write_wb_e) mem[bus.rt_addr_wb_e] = bus.rt_wb_e;
    end
    q.push_back(e);
    @(negedge clk);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl", W'({bus.op, bus.format, bus.unit, bus.rt_addr, bus.imm, bus.reg_write}), W'(e.ctl));
      chk("ra", bus.ra, e.ra);
      chk("rb", bus.rb, e.rb);
      chk("rc", bus.rc, e.rc);
    end
  end
  initial begin
    reset = 1'b1;
    clr();
    for (int i = 0; i < NREG; i++) mem[i] = 'x;
    cyc();
    cyc();
    reset = 1'b0;
    {bus.ra_addr, bus.rb_addr, bus.rc_addr} = {7'd5, 7'd6, 7'd7};
    cyc();
    clr();
    bus.reg_write_wb_e = 1'b1;
    bus.rt_addr_wb_e = 7'd5;
    bus.rt_wb_e = {16{8'hAA}};
    cyc();
    clr();
    bus.ra_addr = 7'd5;
    cyc();
    bus.reg_write_wb_e = 1'b1;
    bus.rt_addr_wb_e = 7'd8;
    bus.rt_wb_e = {16{8'hAA}};
    bus.ra_addr = 7'd8;
    cyc();
    clr();
    bus.reg_write_wb_o = 1'b1;
    bus.rt_addr_wb_o = 7'd9;
    bus.rt_wb_o = {16{8'h33}};
    cyc();
    clr();
    bus.rb_addr = 7'd9;
    bus.fw_write_e[4] = 1'b1;
    bus.fw_addr_e[4] = 7'd9;
    bus.fw_e[4] = {16{8'h11}};
    bus.fw_write_e[2] = 1'b1;
    bus.fw_addr_e[2] = 7'd9;
    bus.fw_e[2] = {16{8'h22}};
    cyc();
    clr();
    bus.rc_addr = 7'd12;
    bus.fw_write_e[3] = 1'b1;
    bus.fw_addr_e[3] = 7'd12;
    bus.fw_e[3] = {32{4'hE}};
    bus.fw_write_o[3] = 1'b1;
    bus.fw_addr_o[3] = 7'd12;
    cyc();
    bus.fw_write_e[3] = 1'b0;
    cyc();
    clr();
    bus.reg_write_wb_e = 1'b1;
    bus.rt_addr_wb_e = 7'd20;
    bus.rt_wb_e = {32{4'h1}};
    bus.reg_write_wb_o = 1'b1;
    bus.rt_addr_wb_o = 7'd20;
    bus.rt_wb_o = {32{4'h2}};
    bus.ra_addr = 7'd20;
    cyc();
    clr();
    bus.rb_addr = 7'd20;
    cyc();
    bus.reg_write_in = 1'b1;
    bus.rt_addr_in = 7'd33;
    bus.op_in = 11'h5A5;
    cyc();
    reset = 1'b1;
    bus.reg_write_wb_e = 1'b1;
    bus.rt_addr_wb_e = 7'd40;
    bus.rt_wb_e = rnd();
    cyc();
    reset = 1'b0;
    clr();
    {bus.ra_addr, bus.rb_addr, bus.rc_addr} = {7'd5, 7'd20, 7'd40};
    cyc();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.op_in = 11'($urandom());
      bus.format_in = 3'($urandom());
      bus.unit_in = 2'($urandom());
      bus.rt_addr_in = 7'($urandom());
      bus.imm_in = 18'($urandom());
      bus.reg_write_in = 1'($urandom());
      bus.ra_addr = 7'($urandom_range(0, 15));
      bus.rb_addr = 7'($urandom_range(0, 15));
      bus.rc_addr = 7'($urandom_range(0, 15));
      bus.reg_write_wb_e = 1'($urandom());
      bus.rt_addr_wb_e = 7'($urandom_range(0, 15));
      bus.rt_wb_e = rnd();
      bus.reg_write_wb_o = 1'($urandom());
      bus.rt_addr_wb_o = 7'($urandom_range(0, 15));
      bus.rt_wb_o = rnd();
      for (int i = 0; i < FWD; i++) begin
        bus.fw_write_e[i] = ($urandom_range(0, 3) == 0);
        bus.fw_addr_e[i] = 7'($urandom_range(0, 15));
        bus.fw_e[i] = rnd();
        bus.fw_write_o[i] = ($urandom_range(0, 3) == 0);
        bus.fw_addr_o[i] = 7'($urandom_range(0, 15));
        bus.fw_o[i] = rnd();
      end
      cyc();
    end
    reset = 1'b0;
    clr();
    @(negedge clk);
    @(negedge clk);
    chk("drain", W'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/even_rf_fwd.md
# even_rf_fwd

Register-fetch / forwarding stage directly upstream of the even execution pipe. Holds the 128×128-bit SPU register file, reads the three source operands of the decoded even-pipe instruction, and overrides stale values with results still in flight in the even and odd forwarding chains or at writeback. Registers the resolved operands and decoded fields for one cycle, then presents them to the even pipe's RF/FWD inputs.

## Interface
Parameters:
- NREG, 128, number of architectural registers.
- W, 128, register width in bits.
- FWD, 7, forwarding-chain depth per pipe (entries 0..FWD-1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- op_in  in  11  decoded opcode, bits [0:10].
- format_in  in  3  instruction format.
- unit_in  in  2  execution unit: 0 FP, 1 FX2, 2 Byte, 3 FX1.
- rt_addr_in  in  7  destination register.
- ra_addr, rb_addr, rc_addr  in  7 each  source register addresses.
- imm_in  in  18  immediate.
- reg_write_in  in  1  instruction writes rt.
- rt_wb_e, rt_addr_wb_e, reg_write_wb_e  in  128/7/1  even-pipe writeback port.
- rt_wb_o, rt_addr_wb_o, reg_write_wb_o  in  128/7/1  odd-pipe writeback port.
- fw_e, fw_addr_e, fw_write_e  in  FWD×128 / FWD×7 / FWD  even forwarding chain; index 0 is youngest.
- fw_o, fw_addr_o, fw_write_o  in  same  odd forwarding chain.
- op, format, unit, rt_addr, imm, reg_write  out  11/3/2/7/18/1  registered decoded fields.
- ra, rb, rc  out  128 each  registered resolved operands.

## Operation
- Register file writes on posedge clk:
  - if reg_write_wb_e, regs[rt_addr_wb_e] ← rt_wb_e;
  - if reg_write_wb_o, regs[rt_addr_wb_o] ← rt_wb_o;
  - same address on both ports: even value is stored.
- Operand resolution is combinational, per operand X ∈ {ra, rb, rc}, first match wins:
  - for i = 0..FWD-1, youngest first: fw_e[i] if fw_write_e[i] and fw_addr_e[i]==X_addr; else fw_o[i] under the same condition. At equal index, even beats odd.
  - Then the even writeback port, then the odd writeback port. This is the write-through bypass for a register being written on the same edge.
  - Otherwise regs[X_addr].
- All address compares are full 7-bit equality. Register 0 has no special meaning.
- Write enables gate every match. An entry with a matching address but write bit 0 is ignored.
- Output stage: on each non-reset edge, all outputs ← the resolved operands and the *_in fields.
- No stall input. A new instruction is accepted every cycle.

## Timing
- Latency from decode inputs to outputs: 1 cycle.
- Writeback visibility:
  - a value on a writeback port at edge N is seen by an instruction presented before edge N (via bypass);
  - it is seen from the array by instructions presented after edge N.
- Reset, synchronous:
  - every output is 0 on the cycle after reset is sampled high;
  - all NREG registers are cleared to 0;
  - writes presented during the reset cycle are discarded.
- Reset mid-stream: the in-flight output-stage instruction is dropped and reg_write is 0. Operation resumes on the first cycle after reset deasserts.
- The forwarding inputs are sampled in the same cycle as the *_in fields; no extra skew.

## Structure
- The shared package spu_pkg holds:
  - W, NREG, FWD;
  - the unit encoding constants (UNIT_FP, UNIT_FX2, UNIT_BYTE, UNIT_FX1);
  - the packed chain typedefs: fw_data_t, fw_addr_t.
- One sub-module, fwd_select: purely combinational priority mux for a single operand. It takes the address, the array read value, both chains and both writeback ports. even_rf_fwd instantiates it three times.
- The register array, its write logic and the output register live in even_rf_fwd.

## Test plan
- Reset, then issue ra/rb/rc=5/6/7 with no writes -> ra=rb=rc=0 one cycle later, and every other output is 0.
- Even wb writes r5=0xAAAA…, then a later instruction reads ra=5 with empty chains -> ra=0xAAAA… from the array. Same-cycle read -> also 0xAAAA… via bypass.
- fw_e[4]={r9,0x11…,1} and fw_e[2]={r9,0x22…,1}, with r9 in the array = 0x33… -> rb=0x22… (youngest wins).
- fw_e[3]={r12,0xE…,1} and fw_o[3]={r12,0x0…,1} -> rc=0xE… (even wins at equal index). With fw_write_e[3]=0 -> rc=0x0….
- Both wb ports target r20 with even=0x1…, odd=0x2… -> a later read returns 0x1…, and the same-cycle bypass also gives 0x1….
- Assert reset one cycle after issuing reg_write_in=1 -> next-cycle outputs all 0, and a subsequent read of any register returns 0.
